// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI-Lite request arbiter: FSM state encoding and
// AXI response codes.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping
// to the lowest requester below ptr. The pointer register lives in the parent.
module rr_arbiter
    import axi_lite_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any_req
);

    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;
    logic             hi_found;

    // Descending scans leave the lowest matching index in each candidate.
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        hi_found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                lo_idx = IDX_W'(k);
                if (k >= int'(ptr)) begin
                    hi_idx   = IDX_W'(k);
                    hi_found = 1'b1;
                end
            end
        end
    end

    assign gnt_idx = hi_found ? hi_idx : lo_idx;
    assign any_req = |req;

endmodule

// File: rtl/axi_lite_req_arbiter.sv
// Shares one axi_lite_master user port between NUM_REQ requesters with a
// round-robin grant and strictly one outstanding command.
module axi_lite_req_arbiter
    import axi_lite_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic [NUM_REQ-1:0]                cmd_valid,
    output logic [NUM_REQ-1:0]                cmd_ready,
    input  logic [NUM_REQ-1:0]                cmd_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [DATA_WIDTH-1:0]             rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              busy,
    output logic                              m_wr_req,
    output logic [ADDR_WIDTH-1:0]             m_wr_addr,
    output logic [DATA_WIDTH-1:0]             m_wr_data,
    output logic [DATA_WIDTH/8-1:0]           m_wr_strb,
    input  logic                              m_wr_done,
    input  logic [1:0]                        m_wr_resp,
    output logic                              m_rd_req,
    output logic [ADDR_WIDTH-1:0]             m_rd_addr,
    input  logic [DATA_WIDTH-1:0]             m_rd_data,
    input  logic                              m_rd_done,
    input  logic [1:0]                        m_rd_resp
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int STRB_W = DATA_WIDTH / 8;

    // Handshake: a command transfers on the clock edge where cmd_valid[i] and
    // cmd_ready[i] are both high; cmd_ready only rises in IDLE for the winner,
    // and requesters hold cmd_* stable until then. Responses have no backpressure.

    arb_state_e state, state_nxt;

    logic [IDX_W-1:0]      ptr_q;
    logic [IDX_W-1:0]      grant_q;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  any_req;
    logic                  accept;
    logic                  done_hit;

    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;

    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [STRB_W-1:0]     sel_wstrb;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req     (cmd_valid),
        .ptr     (ptr_q),
        .gnt_idx (gnt_idx),
        .any_req (any_req)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                sel_we    = cmd_we[i];
                sel_addr  = cmd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = cmd_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_wstrb = cmd_wstrb[i*STRB_W +: STRB_W];
            end
        end
    end

    // Gated by aresetn so cmd_ready stays low while reset is held.
    assign accept   = aresetn && (state == ARB_IDLE) && any_req;
    // Only the done pulse matching the latched direction counts.
    assign done_hit = we_q ? m_wr_done : m_rd_done;

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:  if (any_req)  state_nxt = ARB_ISSUE;
            ARB_ISSUE:               state_nxt = ARB_WAIT;
            ARB_WAIT:  if (done_hit) state_nxt = ARB_RESP;
            ARB_RESP:                state_nxt = ARB_IDLE;
            default:                 state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr_q     <= '0;
            grant_q   <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
        end else begin
            if (accept) begin
                grant_q <= gnt_idx;
                we_q    <= sel_we;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                wstrb_q <= sel_wstrb;
            end
            if (state == ARB_WAIT && done_hit) begin
                if (we_q) begin
                    rsp_resp  <= m_wr_resp;
                end else begin
                    rsp_resp  <= m_rd_resp;
                    rsp_rdata <= m_rd_data;
                end
            end
            if (state == ARB_RESP) begin
                ptr_q <= (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            end
        end
    end

    assign cmd_ready = accept ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign rsp_valid = (state == ARB_RESP) ? (NUM_REQ'(1) << grant_q) : '0;
    assign busy      = (state != ARB_IDLE);
    assign m_wr_req  = (state == ARB_ISSUE) && we_q;
    assign m_rd_req  = (state == ARB_ISSUE) && !we_q;
    assign m_wr_addr = addr_q;
    assign m_rd_addr = addr_q;
    assign m_wr_data = wdata_q;
    assign m_wr_strb = wstrb_q;

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// Randomised plus directed bench for axi_lite_req_arbiter: timing-rule based
// reference model, behavioural slave, response scoreboard.
module tb_axi_lite_req_arbiter;
    import axi_lite_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int IW = 2;
    localparam int EW = IW + DW + 2;

    // ---------------- clock / reset ----------------
    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc++;

    // ---------------- DUT signals ----------------
    logic [N-1:0]    cmd_valid, cmd_ready, cmd_we, rsp_valid;
    logic [N*AW-1:0] cmd_addr;
    logic [N*DW-1:0] cmd_wdata;
    logic [N*SW-1:0] cmd_wstrb;
    logic [DW-1:0]   rsp_rdata, m_wr_data, m_rd_data;
    logic [1:0]      rsp_resp, m_wr_resp, m_rd_resp;
    logic            busy, m_wr_req, m_rd_req, m_wr_done, m_rd_done;
    logic [AW-1:0]   m_wr_addr, m_rd_addr;
    logic [SW-1:0]   m_wr_strb;

    logic [N-1:0]  drv_valid, drv_we;
    logic [AW-1:0] drv_addr  [N];
    logic [DW-1:0] drv_wdata [N];
    logic [SW-1:0] drv_wstrb [N];

    assign cmd_valid = drv_valid;
    assign cmd_we    = drv_we;
    always_comb begin
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        for (int i = 0; i < N; i++) begin
            cmd_addr[i*AW +: AW]  = drv_addr[i];
            cmd_wdata[i*DW +: DW] = drv_wdata[i];
            cmd_wstrb[i*SW +: SW] = drv_wstrb[i];
        end
    end

    axi_lite_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
        .m_wr_req(m_wr_req), .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data), .m_wr_strb(m_wr_strb),
        .m_wr_done(m_wr_done), .m_wr_resp(m_wr_resp),
        .m_rd_req(m_rd_req), .m_rd_addr(m_rd_addr), .m_rd_data(m_rd_data),
        .m_rd_done(m_rd_done), .m_rd_resp(m_rd_resp)
    );

    // ---------------- scoreboard / counters ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    // Reference model: accept at T, request at T+1, response at D+1, idle after.
    bit            outstanding = 1'b0;
    int            acc_cyc     = -10;
    int            rsp_due_cyc = -10;
    int            model_ptr   = 0;
    int            cur_idx     = 0;
    logic          cur_we;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata;
    logic [SW-1:0] cur_wstrb;
    logic [DW-1:0] last_rdata  = '0;
    logic [EW-1:0] exp_q[$];
    int            gnt_log[$];
    logic [N-1:0]  acc_flag    = '0;

    // Slave model controls
    bit            sl_pending  = 1'b0;
    int            sl_cnt      = 0;
    bit            sl_we, sl_spur;
    logic [1:0]    sl_resp;
    logic [DW-1:0] sl_rdata;
    bit            force_en    = 1'b0;
    logic [1:0]    force_resp  = RESP_OKAY;
    logic [DW-1:0] force_rdata = '0;
    int            force_delay = 0;
    bit            spur_force  = 1'b0;
    bit            idle_poke   = 1'b0;

    // ---------------- slave (axi_lite_master stand-in) ----------------
    always @(posedge aclk) begin
        #1;
        m_wr_done = 1'b0;
        m_rd_done = 1'b0;
        if (!aresetn) begin
            sl_pending = 1'b0;
        end else if (sl_pending) begin
            sl_cnt--;
            if (sl_cnt == 0) begin
                logic [DW-1:0] e_rdata;
                if (sl_we) begin
                    m_wr_done = 1'b1;
                    m_wr_resp = sl_resp;
                    e_rdata   = last_rdata;
                end else begin
                    m_rd_done  = 1'b1;
                    m_rd_resp  = sl_resp;
                    m_rd_data  = sl_rdata;
                    e_rdata    = sl_rdata;
                    last_rdata = sl_rdata;
                end
                exp_q.push_back({IW'(cur_idx), e_rdata, sl_resp});
                rsp_due_cyc = cyc + 1;
                sl_pending  = 1'b0;
            end else if (sl_spur) begin
                sl_spur = 1'b0;
                if (sl_we) begin
                    m_rd_done = 1'b1;
                    m_rd_resp = RESP_DECERR;
                    m_rd_data = $urandom;
                end else begin
                    m_wr_done = 1'b1;
                    m_wr_resp = RESP_DECERR;
                end
            end
        end else if (idle_poke) begin
            idle_poke = 1'b0;
            m_wr_done = 1'b1;
            m_rd_done = 1'b1;
            m_wr_resp = RESP_SLVERR;
            m_rd_resp = RESP_SLVERR;
            m_rd_data = $urandom;
        end
    end

    // ---------------- monitor ----------------
    logic [N-1:0]  exp_rdy;
    int            win;
    bit            exp_req, exp_rsp;
    logic [EW-1:0] ent;

    always @(negedge aclk) begin
        if (!aresetn) begin
            chk("reset_outputs", |{cmd_ready, rsp_valid, rsp_rdata, rsp_resp, busy, m_wr_req,
                m_wr_addr, m_wr_data, m_wr_strb, m_rd_req, m_rd_addr}, 0);
            outstanding = 1'b0;
            rsp_due_cyc = -10;
            model_ptr   = 0;
            last_rdata  = '0;
            acc_flag    = '0;
            exp_q.delete();
        end else begin
            chk("busy", busy, outstanding);

            exp_req = outstanding && (cyc == acc_cyc + 1);
            if (exp_req || m_wr_req || m_rd_req) begin
                chk("m_wr_req", m_wr_req, exp_req && cur_we);
                chk("m_rd_req", m_rd_req, exp_req && !cur_we);
                if (exp_req) begin
                    if (cur_we) begin
                        chk("m_wr_addr", m_wr_addr, cur_addr);
                        chk("m_wr_data", m_wr_data, cur_wdata);
                        chk("m_wr_strb", m_wr_strb, cur_wstrb);
                    end else begin
                        chk("m_rd_addr", m_rd_addr, cur_addr);
                    end
                    sl_pending = 1'b1;
                    sl_we      = cur_we;
                    sl_cnt     = (force_delay != 0) ? force_delay : $urandom_range(1, 4);
                    sl_spur    = spur_force || (!force_en && $urandom_range(0, 3) == 0);
                    sl_resp    = force_en ? force_resp : 2'($urandom_range(0, 3));
                    sl_rdata   = force_en ? force_rdata : $urandom;
                end
            end

            exp_rdy = '0;
            win     = -1;
            if (!outstanding) begin
                for (int k = 0; k < N; k++) begin
                    if (win < 0 && drv_valid[(model_ptr + k) % N]) win = (model_ptr + k) % N;
                end
                if (win >= 0) exp_rdy = onehot(win);
            end
            if (exp_rdy != 0 || cmd_ready != 0) chk("cmd_ready", cmd_ready, exp_rdy);

            exp_rsp = outstanding && (cyc == rsp_due_cyc);
            if (exp_rsp) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_queue_empty", 1, 0);
                end else begin
                    ent = exp_q.pop_front();
                    chk("rsp_valid", rsp_valid, onehot(int'(ent[EW-1 -: IW])));
                    chk("rsp_rdata", rsp_rdata, ent[DW+1:2]);
                    chk("rsp_resp", rsp_resp, ent[1:0]);
                end
                outstanding = 1'b0;
                model_ptr   = (cur_idx + 1) % N;
            end else if (rsp_valid != 0) begin
                chk("rsp_valid_unexpected", rsp_valid, 0);
            end

            if (win >= 0) begin
                outstanding   = 1'b1;
                acc_cyc       = cyc;
                cur_idx       = win;
                cur_we        = drv_we[win];
                cur_addr      = drv_addr[win];
                cur_wdata     = drv_wdata[win];
                cur_wstrb     = drv_wstrb[win];
                acc_flag[win] = 1'b1;
                gnt_log.push_back(win);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_cmd(input int i, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [SW-1:0] strb);
        drv_we[i]    = we;
        drv_addr[i]  = addr;
        drv_wdata[i] = data;
        drv_wstrb[i] = strb;
        drv_valid[i] = 1'b1;
    endtask

    task automatic step(input int prob);
        @(posedge aclk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_flag[i]) begin
                drv_valid[i] = 1'b0;
                acc_flag[i]  = 1'b0;
            end
            if (!drv_valid[i] && prob > 0 && $urandom_range(0, 99) < prob)
                set_cmd(i, 1'($urandom_range(0, 1)), $urandom, $urandom, SW'($urandom));
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while ((outstanding || drv_valid != 0) && k < budget) begin
            step(0);
            k++;
        end
        if (k >= budget) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, budget);
        end
        step(0);
    endtask

    task automatic chk_grants(input string name, input int g0, input int g1, input int g2, input int g3);
        int exp_g[4];
        exp_g = '{g0, g1, g2, g3};
        chk({name, "_count"}, gnt_log.size(), 4);
        for (int k = 0; k < 4 && k < gnt_log.size(); k++)
            chk(name, gnt_log[k], exp_g[k]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        drv_valid = '0;
        drv_we    = '0;
        for (int i = 0; i < N; i++) begin
            drv_addr[i]  = '0;
            drv_wdata[i] = '0;
            drv_wstrb[i] = '0;
        end
        m_wr_done = 1'b0;
        m_rd_done = 1'b0;
        m_wr_resp = '0;
        m_rd_resp = '0;
        m_rd_data = '0;

        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        step(0);

        // done pulses while idle must be ignored
        idle_poke = 1'b1;
        repeat (4) step(0);

        // single write, single read
        force_en = 1'b1;
        force_resp = RESP_OKAY;
        set_cmd(1, 1'b1, 32'h10, 32'hA5A5_0001, 4'hF);
        wait_idle("single_write", 40);
        force_rdata = 32'hDEAD_BEEF;
        set_cmd(2, 1'b0, 32'h20, 32'h0, 4'h0);
        wait_idle("single_read", 40);
        set_cmd(3, 1'b1, 32'h30, 32'h3333_3333, 4'h3);
        wait_idle("ptr_to_zero", 40);

        // all four at once from ptr 0, then from ptr 2
        gnt_log.delete();
        for (int i = 0; i < N; i++) set_cmd(i, 1'(i % 2), 32'h100 + 32'(i), 32'hC0DE_0000 + 32'(i), 4'hF);
        wait_idle("all_ptr0", 100);
        chk_grants("grants_ptr0", 0, 1, 2, 3);
        set_cmd(1, 1'b0, 32'h40, 32'h0, 4'h0);
        wait_idle("ptr_to_two", 40);
        gnt_log.delete();
        for (int i = 0; i < N; i++) set_cmd(i, 1'((i + 1) % 2), 32'h200 + 32'(i), 32'hBEEF_0000 + 32'(i), 4'h5);
        wait_idle("all_ptr2", 100);
        chk_grants("grants_ptr2", 2, 3, 0, 1);

        // SLVERR on a write, spurious rd_done during a write wait
        force_resp = RESP_SLVERR;
        set_cmd(0, 1'b1, 32'h50, 32'h1234_5678, 4'hC);
        wait_idle("slverr_write", 40);
        force_resp  = RESP_OKAY;
        force_delay = 4;
        spur_force  = 1'b1;
        set_cmd(3, 1'b1, 32'h60, 32'h8765_4321, 4'hF);
        wait_idle("spurious_done", 40);
        spur_force  = 1'b0;

        // reset while waiting for the master
        force_delay = 6;
        set_cmd(1, 1'b1, 32'h70, 32'hFACE_0001, 4'hF);
        begin
            int k = 0;
            while (!(outstanding && cyc >= acc_cyc + 2) && k < 20) begin
                step(0);
                k++;
            end
            chk("reached_wait", outstanding && cyc >= acc_cyc + 2, 1);
        end
        aresetn   = 1'b0;
        drv_valid = '0;
        repeat (2) step(0);
        aresetn     = 1'b1;
        force_delay = 0;
        force_rdata = 32'h0BAD_F00D;
        gnt_log.delete();
        set_cmd(3, 1'b0, 32'h80, 32'h0, 4'h0);
        wait_idle("after_reset", 40);
        chk("after_reset_grant", gnt_log.size() > 0 ? gnt_log[0] : -1, 3);

        // randomised traffic
        force_en = 1'b0;
        repeat (1500) step(35);
        wait_idle("random", 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
